ifft_buf_sched: RTL and testbench
=================================

Name: ifft_buf_sched

Overview:
Sequencer and port arbiter for the 32x28-bit IFFT sample buffer (single write port, combinational read port).
- Loads one 32-sample frame from an input stream, in bit-reversed or natural order.
- Hands exclusive buffer ownership to the IFFT butterfly engine via start/done.
- Streams the transformed frame out in natural order, then returns to loading.
- Sits between the sample source, the buffer and the butterfly engine.

Parameters:
AW, 5, buffer address width; frame length is 2**AW = 32 samples.
DW, 28, sample width (packed complex word).
BITREV, 1, 1 = load writes use bit-reversed address; 0 = natural order.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input sample
in_data  in  DW  input sample
eng_start  out  1  one-cycle pulse: engine owns buffer
eng_done  in  1  engine finished (sampled in COMPUTE only)
eng_waddr  in  AW  engine write address
eng_wdata  in  DW  engine write data
eng_write  in  1  engine write enable
eng_raddr  in  AW  engine read address
eng_rdata  out  DW  buffer read data to engine
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  DW  output sample
out_last  out  1  marks sample 31 of the output frame
mem_waddr  out  AW  to buffer write address
mem_wdata  out  DW  to buffer write data
mem_write  out  1  to buffer write enable
mem_raddr  out  AW  to buffer read address
mem_rdata  in  DW  from buffer, combinational on mem_raddr
frame_cnt  out  8  completed output frames, wraps 255->0

Behaviour:
State register: LOAD, START, COMPUTE, DRAIN; 5-bit counters wcnt, rcnt.
- All outputs are decoded from registered state/counters. Only the data/address muxes are combinational.

Reset (synchronous):
- state=LOAD, wcnt=0, rcnt=0, frame_cnt=0.
- Hence in_ready=1, eng_start=0, out_valid=0, out_last=0, mem_write=0.
- Reset mid-frame abandons the frame. Buffer contents are not cleared.

LOAD:
- in_ready=1.
- On in_valid&&in_ready: mem_write=1, mem_wdata=in_data, mem_waddr = BITREV ? bit-reverse(wcnt) : wcnt, wcnt<=wcnt+1.
- When the accepted sample has wcnt==31: wcnt<=0, state<=START.
- in_valid low stalls with no write and no count.

START:
- Exactly one cycle. eng_start=1, in_ready=0, mem_write=0. state<=COMPUTE.

COMPUTE:
- Engine owns the buffer: mem_waddr=eng_waddr, mem_wdata=eng_wdata, mem_write=eng_write, mem_raddr=eng_raddr.
- eng_rdata=mem_rdata, read in the same cycle.
- eng_done=1 moves state to DRAIN next cycle. An engine write in the same cycle as eng_done is still performed.
- No timeout.

DRAIN:
- mem_raddr=rcnt, out_data=mem_rdata, out_valid=1, out_last=(rcnt==31).
- On out_ready: rcnt<=rcnt+1.
- On the out_last handshake: rcnt<=0, frame_cnt<=frame_cnt+1, state<=LOAD.
- out_data must remain stable while out_valid&&!out_ready.

Port isolation:
- Outside COMPUTE, eng_write/eng_done are ignored and never reach the buffer.
- Outside LOAD, in_valid is ignored.
- eng_rdata = mem_rdata in all states (don't-care outside COMPUTE).
- mem_raddr = rcnt outside COMPUTE.

Timing:
- A buffer write is visible on the read port the cycle after its clock edge.
- Latency from the first input accept to the first out_valid is 32 + 1 + (engine cycles) + 1 cycles minimum.
- Back-to-back frames: LOAD re-entered the cycle after the last output handshake, so in_ready rises that cycle.

Test Plan:
1. BITREV=1, engine models done one cycle after start without writes. Input 0..31 continuously -> buffer address 1 holds 16, address 31 holds 31. Output stream reads in natural order: 0,16,8,24,...,31, out_last on 32nd, frame_cnt=1.
2. in_valid toggled every other cycle during LOAD -> exactly 32 writes, eng_start is a single pulse after the 32nd accept, in_ready=0 from START until DRAIN ends.
3. Engine writes mem[k]=k+100 for all k in COMPUTE, then eng_done -> output 100..131 in order. In_valid held high during COMPUTE causes no buffer write.
4. out_ready low for 3 cycles at rcnt=5 -> out_data holds sample 5 stable and rcnt holds; out_last only at rcnt=31.
5. rst asserted at wcnt=17 in LOAD and again during COMPUTE -> next cycle state=LOAD, wcnt=0, out_valid=0, eng_start=0. A following full frame completes normally.
6. 256 complete frames -> frame_cnt wraps to 0. Two frames back-to-back with in_valid always 1 -> in_ready rises the cycle after the out_last handshake.

Source files
------------

// File: rtl/ifft_buf_sched.sv
// ifft_buf_sched: load/compute/drain sequencer and port arbiter for the IFFT sample buffer
module ifft_buf_sched #(
  parameter int AW = 5,
  parameter int DW = 28,
  parameter bit BITREV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          eng_start,
  input  logic          eng_done,
  input  logic [AW-1:0] eng_waddr,
  input  logic [DW-1:0] eng_wdata,
  input  logic          eng_write,
  input  logic [AW-1:0] eng_raddr,
  output logic [DW-1:0] eng_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    frame_cnt
);
  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, COMPUTE = 2'd2, DRAIN = 2'd3;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wrev;
  logic [7:0] frame_q, frame_d;
  logic comp, in_fire, out_fire;
  genvar i;
  for (i = 0; i < AW; i++) begin : g_rev
    assign wrev[i] = wcnt_q[AW-1-i];
  end
  assign in_ready  = state_q == LOAD;
  assign eng_start = state_q == START;
  assign comp      = state_q == COMPUTE;
  assign out_valid = state_q == DRAIN;
  assign out_last  = out_valid && &rcnt_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // The engine owns every buffer port while computing; otherwise load writes and drain reads.
  assign mem_write = comp ? eng_write : in_fire;
  assign mem_waddr = comp ? eng_waddr : (BITREV ? wrev : wcnt_q);
  assign mem_wdata = comp ? eng_wdata : in_data;
  assign mem_raddr = comp ? eng_raddr : rcnt_q;
  assign eng_rdata = mem_rdata;
  assign out_data  = mem_rdata;
  assign frame_cnt = frame_q;
  always_comb begin
    wcnt_d  = in_fire ? wcnt_q + 1'b1 : wcnt_q;
    rcnt_d  = out_fire ? rcnt_q + 1'b1 : rcnt_q;
    frame_d = frame_q + {7'd0, out_fire && out_last};
    state_d = (in_fire && &wcnt_q) ? START :
              eng_start            ? COMPUTE :
              (comp && eng_done)   ? DRAIN :
              (out_fire && out_last) ? LOAD : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: tb/tb_ifft_buf_sched.sv
// tb_ifft_buf_sched: directed scenario bench with a behavioural buffer and engine
module tb_ifft_buf_sched;
  localparam int AW = 5, DW = 28;
  logic clk = 0, rst = 1;
  logic in_valid, in_ready, eng_start, eng_done, eng_write, out_valid, out_ready, out_last, mem_write;
  logic [DW-1:0] in_data, eng_wdata, eng_rdata, out_data, mem_wdata, mem_rdata;
  logic [AW-1:0] eng_waddr, eng_raddr, mem_waddr, mem_raddr;
  logic [7:0] frame_cnt;
  logic [DW-1:0] mem [32];
  int pass_cnt = 0, tot_cnt = 0;

  ifft_buf_sched #(.AW(AW), .DW(DW), .BITREV(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_start(eng_start), .eng_done(eng_done), .eng_waddr(eng_waddr), .eng_wdata(eng_wdata),
    .eng_write(eng_write), .eng_raddr(eng_raddr), .eng_rdata(eng_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_write) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  function automatic logic [4:0] rev5(input logic [4:0] a);
    for (int i = 0; i < 5; i++) rev5[i] = a[4-i];
  endfunction

  task automatic idle();
    in_valid = 0; in_data = 0; eng_done = 0; eng_write = 0;
    eng_waddr = 0; eng_wdata = 0; eng_raddr = 0; out_ready = 0;
  endtask

  // Leaves the bench at the falling edge where the DUT sits in START.
  task automatic load(input int base);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); in_valid = 1; in_data = DW'(base + k);
    end
    @(negedge clk); in_valid = 0;
  endtask

  task automatic engine_pass();
    @(negedge clk); eng_done = 1;
    @(negedge clk); eng_done = 0;
  endtask

  task automatic drain_all();
    out_ready = 1;
    repeat (32) @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    tot_cnt++; if (eng_start !== 1'b0) $display("FAIL reset_eng_start: got %b want 0", eng_start); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    tot_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else pass_cnt++;
    tot_cnt++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b want 0", mem_write); else pass_cnt++;
    tot_cnt++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else pass_cnt++;
    tot_cnt++; if (mem_raddr !== 5'd0) $display("FAIL reset_mem_raddr: got %0d want 0", mem_raddr); else pass_cnt++;
  endtask

  task automatic test_bitrev_frame();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); in_valid = 1; in_data = DW'(k); #1;
      tot_cnt++;
      if ({mem_write, mem_waddr, mem_wdata} !== {1'b1, rev5(5'(k)), DW'(k)})
        $display("FAIL load_write[%0d]: got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d", k, mem_write, mem_waddr, mem_wdata, rev5(5'(k)), k);
      else pass_cnt++;
    end
    @(negedge clk); in_valid = 0; #1;
    tot_cnt++; if ({eng_start, in_ready} !== 2'b10) $display("FAIL start_pulse: got start=%b rdy=%b want 1 0", eng_start, in_ready); else pass_cnt++;
    @(negedge clk); eng_done = 1; #1;
    tot_cnt++; if (eng_start !== 1'b0) $display("FAIL start_single: got %b want 0", eng_start); else pass_cnt++;
    @(negedge clk); eng_done = 0;
    tot_cnt++; if (mem[1] !== DW'(16)) $display("FAIL mem1: got %0d want 16", mem[1]); else pass_cnt++;
    tot_cnt++; if (mem[31] !== DW'(31)) $display("FAIL mem31: got %0d want 31", mem[31]); else pass_cnt++;
    out_ready = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      tot_cnt++;
      if ({out_valid, out_last, out_data} !== {1'b1, k == 31, DW'(rev5(5'(k)))})
        $display("FAIL drain_bitrev[%0d]: got v=%b l=%b d=%0d want v=1 l=%b d=%0d", k, out_valid, out_last, out_data, k == 31, rev5(5'(k)));
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 0; #1;
    tot_cnt++; if ({in_ready, out_valid, frame_cnt} !== {2'b10, 8'd1}) $display("FAIL after_frame1: got rdy=%b v=%b fc=%0d want 1 0 1", in_ready, out_valid, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_toggle_load();
    int writes = 0, starts = 0, start_c = -1, rdy_bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk); in_valid = (c % 2) == 0; in_data = DW'(c); #1;
      writes += int'(mem_write);
      starts += int'(eng_start);
      if (eng_start) start_c = c;
      if (c >= 63 && in_ready) rdy_bad++;
    end
    in_valid = 0;
    tot_cnt++; if (writes != 32) $display("FAIL toggle_writes: got %0d want 32", writes); else pass_cnt++;
    tot_cnt++; if (starts != 1) $display("FAIL toggle_starts: got %0d want 1", starts); else pass_cnt++;
    tot_cnt++; if (start_c != 63) $display("FAIL toggle_start_cycle: got %0d want 63", start_c); else pass_cnt++;
    @(negedge clk); eng_done = 1;
    @(negedge clk); eng_done = 0; out_ready = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      if (in_ready) rdy_bad++;
      tot_cnt++;
      if (out_data !== DW'(2 * rev5(5'(k)))) $display("FAIL toggle_drain[%0d]: got %0d want %0d", k, out_data, 2 * rev5(5'(k))); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 0; #1;
    tot_cnt++; if (rdy_bad != 0) $display("FAIL toggle_in_ready_low: got %0d high cycles want 0", rdy_bad); else pass_cnt++;
    tot_cnt++; if ({in_ready, frame_cnt} !== {1'b1, 8'd2}) $display("FAIL toggle_end: got rdy=%b fc=%0d want 1 2", in_ready, frame_cnt); else pass_cnt++;
  endtask

  task automatic test_engine_write();
    load(0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = DW'(999);
      eng_write = 1; eng_waddr = 5'(k); eng_wdata = DW'(k + 100); eng_raddr = 5'(k);
      eng_done = k == 31; #1;
      tot_cnt++;
      if ({mem_write, mem_waddr, mem_wdata, mem_raddr, eng_rdata} !== {1'b1, 5'(k), DW'(k + 100), 5'(k), DW'(rev5(5'(k)))})
        $display("FAIL eng_port[%0d]: got we=%b wa=%0d wd=%0d ra=%0d rd=%0d want 1 %0d %0d %0d %0d", k, mem_write, mem_waddr, mem_wdata, mem_raddr, eng_rdata, k, k + 100, k, rev5(5'(k)));
      else pass_cnt++;
    end
    @(negedge clk); eng_done = 0; out_ready = 1;
    for (int k = 0; k < 32; k++) begin
      in_valid = k != 31; #1;
      tot_cnt++;
      if ({mem_write, out_data} !== {1'b0, DW'(k + 100)}) $display("FAIL eng_drain[%0d]: got we=%b d=%0d want 0 %0d", k, mem_write, out_data, k + 100); else pass_cnt++;
      @(negedge clk);
    end
    idle(); #1;
    tot_cnt++; if (frame_cnt !== 8'd3) $display("FAIL eng_frame_cnt: got %0d want 3", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    load(0);
    engine_pass();
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        out_ready = 0;
        repeat (3) begin
          #1;
          tot_cnt++;
          if ({out_valid, out_last, mem_raddr, out_data} !== {2'b10, 5'd5, DW'(20)})
            $display("FAIL stall_hold: got v=%b l=%b ra=%0d d=%0d want 1 0 5 20", out_valid, out_last, mem_raddr, out_data);
          else pass_cnt++;
          @(negedge clk);
        end
      end
      out_ready = 1; #1;
      tot_cnt++;
      if ({out_last, out_data} !== {k == 31, DW'(rev5(5'(k)))}) $display("FAIL stall_drain[%0d]: got l=%b d=%0d want %b %0d", k, out_last, out_data, k == 31, rev5(5'(k))); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 0; #1;
    tot_cnt++; if (frame_cnt !== 8'd4) $display("FAIL stall_frame_cnt: got %0d want 4", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 17; k++) begin
      @(negedge clk); in_valid = 1; in_data = DW'(k);
    end
    @(negedge clk); in_valid = 0; rst = 1;
    @(negedge clk); rst = 0; in_valid = 1; #1;
    tot_cnt++;
    if ({in_ready, eng_start, out_valid, mem_write, mem_waddr, frame_cnt} !== {4'b1001, 5'd0, 8'd0})
      $display("FAIL rst_load: got rdy=%b st=%b v=%b we=%b wa=%0d fc=%0d want 1 0 0 1 0 0", in_ready, eng_start, out_valid, mem_write, mem_waddr, frame_cnt);
    else pass_cnt++;
    in_valid = 0;
    load(0);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; eng_write = 0; #1;
    tot_cnt++;
    if ({in_ready, eng_start, out_valid, mem_write} !== 4'b1000)
      $display("FAIL rst_compute: got rdy=%b st=%b v=%b we=%b want 1 0 0 0", in_ready, eng_start, out_valid, mem_write);
    else pass_cnt++;
    load(200);
    engine_pass();
    out_ready = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      tot_cnt++;
      if (out_data !== DW'(200 + rev5(5'(k)))) $display("FAIL rst_frame[%0d]: got %0d want %0d", k, out_data, 200 + rev5(5'(k))); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 0; #1;
    tot_cnt++; if (frame_cnt !== 8'd1) $display("FAIL rst_frame_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap_back_to_back();
    repeat (254) begin load(0); engine_pass(); drain_all(); end
    #1;
    tot_cnt++; if (frame_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_cnt); else pass_cnt++;
    load(0); engine_pass(); drain_all(); #1;
    tot_cnt++; if (frame_cnt !== 8'd0) $display("FAIL wrap_0: got %0d want 0", frame_cnt); else pass_cnt++;
    in_valid = 1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 32; k++) begin
        if (k != 0 || f == 0) @(negedge clk);
        in_data = DW'(k);
      end
      @(negedge clk);
      engine_pass();
      out_ready = 1;
      for (int k = 0; k < 31; k++) @(negedge clk);
      #1;
      tot_cnt++; if ({out_valid, out_last} !== 2'b11) $display("FAIL b2b_last[%0d]: got v=%b l=%b want 1 1", f, out_valid, out_last); else pass_cnt++;
      @(negedge clk); out_ready = 0; in_data = 0; #1;
      tot_cnt++;
      if ({in_ready, mem_write, mem_waddr, out_valid} !== {2'b11, 5'd0, 1'b0})
        $display("FAIL b2b_reload[%0d]: got rdy=%b we=%b wa=%0d v=%b want 1 1 0 0", f, in_ready, mem_write, mem_waddr, out_valid);
      else pass_cnt++;
    end
    in_valid = 0;
    tot_cnt++; if (frame_cnt !== 8'd2) $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_bitrev_frame();
    test_toggle_load();
    test_engine_write();
    test_backpressure();
    test_reset_mid();
    test_wrap_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
